// File: rtl/rf_dump_reader.sv
// rf_dump_reader
// Debug read-out engine for the 32-entry register file. A start pulse freezes
// the CPU (halt_req), walks a contiguous address range that may wrap past the
// top of the file, reads each register through a combinational RF read port
// and streams the words out over a valid/ready link.
//
// Ports
//   clk, rst               rising-edge clock, async active-high reset
//   start, abort           begin a dump (IDLE only) / cancel a running dump
//   first_addr, last_addr  inclusive range, latched when start is accepted
//   rf_addr, rf_data       RF read port (data valid in the same cycle)
//   out_valid, out_ready   output handshake
//   out_data, out_addr     word and its register index
//   out_last               word is the final one of the range
//   busy, halt_req         dump in progress / CPU freeze request
//   done                   one-cycle pulse after the final handshake
//
// state | meaning
// IDLE  | waiting for start, cur_addr held from the last dump
// FETCH | rf_addr = cur_addr, capture rf_data into the output register
// SEND  | out_valid high, waiting for the handshake
// DONE  | final word delivered, done pulse, back to IDLE

module rf_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              halt_req,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [ADDR_W-1:0] end_addr, end_addr_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [ADDR_W-1:0] out_addr_nxt;
  logic              out_last_nxt;
  logic              out_valid_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      end_addr  <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      end_addr  <= end_addr_nxt;
      out_data  <= out_data_nxt;
      out_addr  <= out_addr_nxt;
      out_last  <= out_last_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    end_addr_nxt  = end_addr;
    out_data_nxt  = out_data;
    out_addr_nxt  = out_addr;
    out_last_nxt  = out_last;
    out_valid_nxt = out_valid;

    case (state)
      IDLE: begin
        // start beats a simultaneous abort; abort has no meaning here anyway
        if (start) begin
          cur_addr_nxt = first_addr;
          end_addr_nxt = last_addr;
          state_nxt    = FETCH;
        end
      end

      FETCH: begin
        if (abort) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
          state_nxt     = IDLE;
        end else begin
          out_data_nxt  = rf_data;
          out_addr_nxt  = cur_addr;
          out_last_nxt  = (cur_addr == end_addr);
          out_valid_nxt = 1'b1;
          state_nxt     = SEND;
        end
      end

      SEND: begin
        // abort wins over a handshake in the same cycle: that word is dropped
        if (abort) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
          state_nxt     = IDLE;
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          if (out_last) begin
            state_nxt = DONE;
          end else begin
            cur_addr_nxt = cur_addr + 1'b1;  // wraps modulo 2^ADDR_W
            state_nxt    = FETCH;
          end
        end
      end

      DONE: begin
        if (abort) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
        end
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rf_addr  = cur_addr;
  assign busy     = (state != IDLE);
  assign halt_req = busy;
  // an abort landing on the DONE cycle suppresses the completion pulse
  assign done     = (state == DONE) && !abort;

endmodule
